// File: rtl/mandelbrot_pixel_scheduler.sv
// rtl/mandelbrot_pixel_scheduler.sv - raster walker feeding one Mandelbrot iterator and writing colours to the framebuffer
module mandelbrot_pixel_scheduler #(
   parameter int W     = 27,
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int AW    = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  cr_start,
   input  logic [W-1:0]  ci_start,
   input  logic [W-1:0]  step,
   input  logic [15:0]   max_iter_in,
   output logic [W-1:0]  cr,
   output logic [W-1:0]  ci,
   output logic [15:0]   max_iterations,
   output logic          iter_reset,
   input  logic          iter_done,
   input  logic [15:0]   iterations,
   output logic          fb_we,
   output logic [AW-1:0] fb_addr,
   output logic [7:0]    fb_data,
   input  logic          fb_ready,
   output logic          busy,
   output logic          frame_done
);

   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_GUARD,
      ST_WAIT,
      ST_WRITE,
      ST_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  cr_q, cr_d;
   logic [W-1:0]  ci_q, ci_d;
   logic [W-1:0]  cr_start_q, cr_start_d;
   logic [W-1:0]  step_q, step_d;
   logic [15:0]   max_iter_q, max_iter_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [AW-1:0] fb_addr_q, fb_addr_d;
   logic [7:0]    fb_data_q, fb_data_d;
   logic          fb_we_q, fb_we_d;
   logic          busy_q, busy_d;

   logic [7:0]    colour;
   logic          last_col;
   logic          last_pixel;

   // Pixels inside the set are black; escaped pixels must never alias to black.
   always_comb begin
      colour = iterations[7:0];
      if (iterations >= max_iter_q) begin
         colour = 8'h00;
      end else if (iterations[7:0] == 8'h00) begin
         colour = 8'h01;
      end
   end

   assign last_col   = (x_q == XW'(H_RES - 1));
   assign last_pixel = last_col && (y_q == YW'(V_RES - 1));

   always_comb begin
      state_d    = state_q;
      cr_d       = cr_q;
      ci_d       = ci_q;
      cr_start_d = cr_start_q;
      step_d     = step_q;
      max_iter_d = max_iter_q;
      x_d        = x_q;
      y_d        = y_q;
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;
      fb_we_d    = fb_we_q;
      busy_d     = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cr_start_d = cr_start;
               step_d     = step;
               max_iter_d = max_iter_in;
               cr_d       = cr_start;
               ci_d       = ci_start;
               x_d        = '0;
               y_d        = '0;
               fb_addr_d  = '0;
               busy_d     = 1'b1;
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH: state_d = ST_GUARD;
         // The iterator's done level still reflects the previous pixel here.
         ST_GUARD:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (iter_done) begin
               fb_data_d = colour;
               fb_we_d   = 1'b1;
               state_d   = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (fb_ready) begin
               fb_we_d = 1'b0;
               if (last_pixel) begin
                  state_d = ST_FIN;
               end else begin
                  if (!last_col) begin
                     x_d  = x_q + XW'(1);
                     cr_d = cr_q + step_q;
                  end else begin
                     x_d  = '0;
                     y_d  = y_q + YW'(1);
                     cr_d = cr_start_q;
                     ci_d = ci_q - step_q;
                  end
                  fb_addr_d = fb_addr_q + AW'(1);
                  state_d   = ST_LAUNCH;
               end
            end
         end
         ST_FIN: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cr_q       <= '0;
         ci_q       <= '0;
         cr_start_q <= '0;
         step_q     <= '0;
         max_iter_q <= '0;
         x_q        <= '0;
         y_q        <= '0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
         fb_we_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cr_q       <= cr_d;
         ci_q       <= ci_d;
         cr_start_q <= cr_start_d;
         step_q     <= step_d;
         max_iter_q <= max_iter_d;
         x_q        <= x_d;
         y_q        <= y_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
         fb_we_q    <= fb_we_d;
         busy_q     <= busy_d;
      end
   end

   assign cr             = cr_q;
   assign ci             = ci_q;
   assign max_iterations = max_iter_q;
   assign iter_reset     = (state_q == ST_LAUNCH);
   assign frame_done     = (state_q == ST_FIN);
   assign fb_we          = fb_we_q;
   assign fb_addr        = fb_addr_q;
   assign fb_data        = fb_data_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// tb/tb_mandelbrot_pixel_scheduler.sv - scoreboard bench for the pixel scheduler on a 4x3 raster
module tb_mandelbrot_pixel_scheduler;

   localparam int W  = 27;
   localparam int HR = 4;
   localparam int VR = 3;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  cr_start, ci_start, step;
   logic [15:0]   max_iter_in;
   logic [W-1:0]  cr, ci;
   logic [15:0]   max_iterations;
   logic          iter_reset;
   logic          iter_done;
   logic [15:0]   iterations;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [7:0]    fb_data;
   logic          fb_ready;
   logic          busy;
   logic          frame_done;

   mandelbrot_pixel_scheduler #(.W(W), .H_RES(HR), .V_RES(VR), .AW(AW)) dut (
      .clk(clk), .reset(rst_n), .start(start),
      .cr_start(cr_start), .ci_start(ci_start), .step(step), .max_iter_in(max_iter_in),
      .cr(cr), .ci(ci), .max_iterations(max_iterations), .iter_reset(iter_reset),
      .iter_done(iter_done), .iterations(iterations),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Iterator stub: done level rises stub_n cycles after iter_reset; stub_hold forces it high.
   logic [15:0] stub_iters;
   int          stub_n;
   logic        stub_hold;
   int          stub_cnt;
   logic        stub_done;

   always @(posedge clk) begin
      if (!rst_n) begin
         stub_done <= 1'b0;
         stub_cnt  <= 0;
      end else if (iter_reset) begin
         stub_done <= 1'b0;
         stub_cnt  <= stub_n;
      end else if (!stub_done) begin
         if (stub_cnt <= 1) stub_done <= 1'b1;
         else stub_cnt <= stub_cnt - 1;
      end
   end
   assign iter_done  = stub_done | stub_hold;
   assign iterations = stub_iters;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic [W-1:0]  cr;
      logic [W-1:0]  ci;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_writes = 0;
   int   n_launch = 0;

   // Hand-computed pixel coordinates for the two views used.
   logic [W-1:0] a_cr [4] = '{27'h7000000, 27'h7400000, 27'h7800000, 27'h7C00000};
   logic [W-1:0] a_ci [3] = '{27'h0800000, 27'h0400000, 27'h0000000};
   logic [W-1:0] b_cr [4] = '{27'h0200000, 27'h0400000, 27'h0600000, 27'h0800000};
   logic [W-1:0] b_ci [3] = '{27'h0000000, 27'h7E00000, 27'h7C00000};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && iter_reset) n_launch++;
      if (rst_n && fb_we && fb_ready) begin
         n_writes++;
         if (sb.size() == 0) begin
            chk("unexpected_write", 64'(fb_addr), 64'hFFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("fb_addr", 64'(fb_addr), 64'(e.addr));
            chk("fb_data", 64'(fb_data), 64'(e.data));
            chk("pixel_cr", 64'(cr), 64'(e.cr));
            chk("pixel_ci", 64'(ci), 64'(e.ci));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input bit use_b, input logic [7:0] data);
      for (int y = 0; y < VR; y++) begin
         for (int x = 0; x < HR; x++) begin
            exp_t e;
            e.addr = AW'(y * HR + x);
            e.data = data;
            e.cr   = use_b ? b_cr[x] : a_cr[x];
            e.ci   = use_b ? b_ci[y] : a_ci[y];
            sb.push_back(e);
         end
      end
   endtask

   task automatic do_start(input logic [W-1:0] c0, input logic [W-1:0] i0,
                           input logic [W-1:0] s, input logic [15:0] m);
      cr_start    = c0;
      ci_start    = i0;
      step        = s;
      max_iter_in = m;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_frame_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, "_frame_done"}, 64'(seen), 64'd1);
      if (seen) begin
         chk({name, "_busy_in_fin"}, 64'(busy), 64'd1);
         tick();
         chk({name, "_busy_after"}, 64'(busy), 64'd0);
         chk({name, "_done_pulse"}, 64'(frame_done), 64'd0);
      end
      chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      cr_start    = '0;
      ci_start    = '0;
      step        = '0;
      max_iter_in = '0;
      fb_ready    = 1'b1;
      stub_iters  = 16'd5;
      stub_n      = 2;
      stub_hold   = 1'b0;
      repeat (3) tick();
      chk("reset_outputs",
          64'({cr, ci, max_iterations, fb_addr, fb_data, fb_we, busy, iter_reset, frame_done}), 64'd0);
      rst_n = 1'b1;
      tick();

      // Frame A, escaped count 5; a second start mid-frame must not relatch.
      push_frame(1'b0, 8'h05);
      do_start(27'h7000000, 27'h0800000, 27'h0400000, 16'd1000);
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("max_iter_latched", 64'(max_iterations), 64'd1000);
      repeat (10) tick();
      do_start(27'h0123456, 27'h0654321, 27'h0000100, 16'd7);
      cr_start = 27'h7000000;
      wait_frame_done("frameA");

      // Reset while waiting on the iterator abandons the frame.
      stub_n = 20;
      do_start(27'h7000000, 27'h0800000, 27'h0400000, 16'd1000);
      repeat (4) tick();
      chk("busy_in_wait", 64'(busy), 64'd1);
      rst_n = 1'b0;
      repeat (2) tick();
      chk("midwait_reset_outputs",
          64'({cr, ci, max_iterations, fb_addr, fb_data, fb_we, busy, iter_reset, frame_done}), 64'd0);
      rst_n = 1'b1;
      tick();

      // Frame B, new view, count equals limit -> black.
      stub_n     = 1;
      stub_iters = 16'd1000;
      push_frame(1'b1, 8'h00);
      do_start(27'h0200000, 27'h0000000, 27'h0200000, 16'd1000);
      wait_frame_done("frameB");

      // Frame A again, count 256 -> 01, first write stalled by fb_ready for 7 cycles.
      stub_n     = 2;
      stub_iters = 16'd256;
      fb_ready   = 1'b0;
      push_frame(1'b0, 8'h01);
      do_start(27'h7000000, 27'h0800000, 27'h0400000, 16'd1000);
      begin
         bit got_we = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (fb_we) begin
               got_we = 1'b1;
               break;
            end
            tick();
         end
         chk("stall_we_seen", 64'(got_we), 64'd1);
      end
      for (int i = 0; i < 7; i++) begin
         chk("stall_hold", 64'({fb_we, fb_addr, fb_data}), 64'({1'b1, 4'd0, 8'h01}));
         tick();
      end
      fb_ready = 1'b1;
      wait_frame_done("frameStall");

      // Done held high throughout: GUARD must not count the stale level.
      stub_hold  = 1'b1;
      stub_iters = 16'd999;
      n_writes   = 0;
      n_launch   = 0;
      push_frame(1'b0, 8'hE7);
      do_start(27'h7000000, 27'h0800000, 27'h0400000, 16'd1000);
      wait_frame_done("frameHold");
      chk("hold_writes", 64'(n_writes), 64'(HR * VR));
      chk("hold_launches", 64'(n_launch), 64'(HR * VR));
      stub_hold = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
